pat_match_fsm: RTL and testbench
================================

Name: pat_match_fsm

Overview:
- Parametrised streaming string/pattern detector; next generation of the fixed "Hello" detector.
- Pattern contents and length are runtime-programmable, up to MAX_LEN symbols of DATA_W bits.
- Runtime choice of overlapping or non-overlapping matches; input is qualified by a valid strobe.
- Sits between a byte-stream source (UART RX or similar) and status/LED logic. Reports each match as a pulse, a toggle and a saturating count.

Parameters:
- DATA_W, 8, symbol width in bits
- MAX_LEN, 8, maximum pattern length in symbols (>=2)
- CNT_W, 16, match counter width

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Data_valid  in  1  Data carries a symbol this cycle
- Data  in  DATA_W  input symbol
- Pat_we  in  1  write Pat_char into pattern slot Pat_addr
- Pat_addr  in  $clog2(MAX_LEN)  pattern slot; 0 = first symbol of pattern
- Pat_char  in  DATA_W  pattern symbol
- Len_we  in  1  write Len_in into length register
- Len_in  in  $clog2(MAX_LEN)+1  pattern length
- Overlap_en  in  1  1 = overlapping matches allowed
- Clr  in  1  synchronous flush of history and counter
- Match_pulse  out  1  one-cycle pulse per match
- Match_toggle  out  1  inverts on every match
- Match_cnt  out  CNT_W  saturating match count

Behaviour:
- Reset (Rst_n low, asynchronous): all pattern slots 0, length 0, history 0, fill 0, Match_pulse 0, Match_toggle 1, Match_cnt 0.
- Storage: pat[0..MAX_LEN-1]; history hist[0..MAX_LEN-1] with hist[0] newest; fill counter 0..MAX_LEN, saturating.
- Config writes:
  - Pat_we writes pat[Pat_addr]. Pat_addr >= MAX_LEN is ignored.
  - Len_we writes len. Values > MAX_LEN saturate to MAX_LEN. len = 0 disables matching.
  - Any config write, or Clr, sets fill to 0 (history flush).
- Priority when events coincide in one cycle: Clr > config write > data beat.
  - A data beat coinciding with a config write or Clr is discarded; no match can occur that cycle.
  - Pat_we and Len_we in the same cycle both take effect.
- Clr also zeroes Match_cnt. Match_toggle is unaffected by Clr.
- Accepted beat (Data_valid=1, no Clr, no config write):
  - History shifts with Data entering hist[0]; fill increments, saturating.
  - A window is formed from the new Data plus the old history.
  - Match when len != 0, new fill >= len, and window symbol (len-1-i) == pat[i] for all i < len (oldest window symbol vs pat[0]).
- Latency: match registered at the accepting edge. Match_pulse is high for exactly the following cycle. Match_toggle and Match_cnt update at the same edge.
- Consecutive matching beats give back-to-back pulses, one per beat.
- Overlap_en=1: fill is kept after a match, so a suffix of the match can start the next one.
- Overlap_en=0: fill is set to 0 at the match edge, so the next match needs len fresh symbols.
- Cycles with Data_valid=0 do not shift history and do not break a partial match. Data is don't-care in those cycles.
- Match_cnt increments per match and holds at all-ones.
- Conceptual FSM per beat: FLUSHED (fill=0) -> FILLING (0<fill<len) -> ARMED (fill>=len, compare each beat).
  - Match with Overlap_en=0 -> FLUSHED.
  - Match with Overlap_en=1 -> stays ARMED.
  - Config write or Clr -> FLUSHED from any state.
- Rst_n asserted mid-stream: immediate return to reset values. Partial matches are lost.

Optional Feature:
- Macro: PAT_MATCH_CNT_EN.
- Defined: Match_cnt counter implemented as described; Clr also clears it.
- Undefined: no counter registers; Match_cnt tied to 0. Match_pulse and Match_toggle are unchanged.

Decomposition:
- Package pat_match_pkg holds:
  - default DATA_W, MAX_LEN, CNT_W constants
  - LEN_W = $clog2(MAX_LEN)+1
  - reset constant TOGGLE_RST = 1'b1
  - conceptual state encoding (FLUSHED/FILLING/ARMED) for bench/coverage use
- One sub-module, pat_window_cmp: purely combinational; takes the window, the pattern array and len; returns a 1-bit equal flag. It is instantiated once.

Test Plan:
- Load "Hello", len 5, Overlap_en=0; stream "xHelloy" with continuous valid -> one Match_pulse, in the cycle after 'o' is accepted; Match_toggle 1->0; Match_cnt=1.
- Pattern "aba", len 3; stream "ababa" -> Overlap_en=1 gives 2 pulses (after beats 3 and 5), cnt=2; Overlap_en=0 gives 1 pulse, cnt=1.
- Stream "Hello" with Data_valid low for 3 cycles between each beat and Data=0xFF during the gaps -> exactly one match.
- len 0 -> no pulses for any stream. Len_in=9 with MAX_LEN=8 -> length reads 8. CNT_W=2 with 5 matches -> Match_cnt holds 3.
- Feed "Hel", assert Rst_n low one cycle, then feed "lo" -> no match; outputs back to reset values (toggle=1, cnt=0).
- Feed "Hell", then Pat_we concurrent with valid 'o' -> beat dropped, no pulse; a following fresh "Hello" matches once.

Source files
------------

// File: rtl/pat_match_pkg.sv
// Shared constants and types for the programmable pattern detector.
// Optional match counter: define PAT_MATCH_CNT_EN.
package pat_match_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN) + 1;

    localparam logic TOGGLE_RST = 1'b1;

    typedef enum logic [1:0] {
        ST_FLUSHED,
        ST_FILLING,
        ST_ARMED
    } match_state_e;

    function automatic match_state_e state_of(
        input int unsigned fill,
        input int unsigned len
    );
        if (fill == 0)
            return ST_FLUSHED;
        else if (fill < len)
            return ST_FILLING;
        else
            return ST_ARMED;
    endfunction

endpackage

// File: rtl/pat_window_cmp.sv
// Compares the newest len window symbols against the programmed pattern.
// Oldest window symbol lines up with pat[0].
module pat_window_cmp #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8
) (
    input  logic [MAX_LEN-1:0][DATA_W-1:0] window,
    input  logic [MAX_LEN-1:0][DATA_W-1:0] pat,
    input  logic [$clog2(MAX_LEN):0]       len,
    output logic                           eq
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;

    logic [LW-1:0] idx;

    always_comb begin
        eq  = 1'b1;
        idx = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            idx = len - LW'(1) - LW'(i);
            if (LW'(i) < len && window[idx[AW-1:0]] != pat[i])
                eq = 1'b0;
        end
    end

endmodule

// File: rtl/pat_match_fsm.sv
// Streaming detector for a runtime-programmable pattern.
// Match_cnt exists only when PAT_MATCH_CNT_EN is defined.
module pat_match_fsm
    import pat_match_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Data_valid,
    input  logic [DATA_W-1:0]          Data,
    input  logic                       Pat_we,
    input  logic [$clog2(MAX_LEN)-1:0] Pat_addr,
    input  logic [DATA_W-1:0]          Pat_char,
    input  logic                       Len_we,
    input  logic [$clog2(MAX_LEN):0]   Len_in,
    input  logic                       Overlap_en,
    input  logic                       Clr,
    output logic                       Match_pulse,
    output logic                       Match_toggle,
    output logic [CNT_W-1:0]           Match_cnt
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;

    logic [MAX_LEN-1:0][DATA_W-1:0] pat;
    logic [MAX_LEN-1:0][DATA_W-1:0] hist;
    logic [MAX_LEN-1:0][DATA_W-1:0] window;
    logic [LW-1:0]                  len;
    logic [LW-1:0]                  fill;
    logic [LW-1:0]                  fill_nxt;
    logic                           cfg_wr;
    logic                           accept;
    logic                           win_eq;
    logic                           hit;

    // window[0] is the incoming symbol, the rest is the old history
    assign window   = {hist[MAX_LEN-2:0], Data};
    assign fill_nxt = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
    assign cfg_wr   = Pat_we | Len_we;
    assign accept   = Data_valid & ~Clr & ~cfg_wr;
    assign hit      = accept & (len != '0) & (fill_nxt >= len) & win_eq;

    pat_window_cmp #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN)
    ) u_cmp (
        .window (window),
        .pat    (pat),
        .len    (len),
        .eq     (win_eq)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pat          <= '0;
            hist         <= '0;
            len          <= '0;
            fill         <= '0;
            Match_pulse  <= 1'b0;
            Match_toggle <= TOGGLE_RST;
        end else begin
            Match_pulse <= hit;
            if (hit)
                Match_toggle <= ~Match_toggle;
            if (Clr) begin
                fill <= '0;
            end else if (cfg_wr) begin
                if (Pat_we && {1'b0, Pat_addr} < LW'(MAX_LEN))
                    pat[Pat_addr] <= Pat_char;
                if (Len_we)
                    len <= (Len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : Len_in;
                fill <= '0;
            end else if (Data_valid) begin
                hist <= window;
                fill <= (hit && !Overlap_en) ? '0 : fill_nxt;
            end
        end
    end

`ifdef PAT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            cnt_q <= '0;
        else if (Clr)
            cnt_q <= '0;
        else if (hit && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign Match_cnt = cnt_q;
`else
    assign Match_cnt = '0;
`endif

endmodule

// File: tb/tb_pat_match_fsm.sv
// Directed and random stimulus for pat_match_fsm against a queue-based model.
module tb_pat_match_fsm;
    import pat_match_pkg::*;

    localparam int DW   = 8;
    localparam int ML   = 8;
    localparam int CW   = 2;
    localparam int AW   = $clog2(ML);
    localparam int LW   = AW + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk;
    logic          Rst_n;
    logic          Data_valid;
    logic [DW-1:0] Data;
    logic          Pat_we;
    logic [AW-1:0] Pat_addr;
    logic [DW-1:0] Pat_char;
    logic          Len_we;
    logic [LW-1:0] Len_in;
    logic          Overlap_en;
    logic          Clr;
    logic          Match_pulse;
    logic          Match_toggle;
    logic [CW-1:0] Match_cnt;

    pat_match_fsm #(
        .DATA_W  (DW),
        .MAX_LEN (ML),
        .CNT_W   (CW)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Data_valid   (Data_valid),
        .Data         (Data),
        .Pat_we       (Pat_we),
        .Pat_addr     (Pat_addr),
        .Pat_char     (Pat_char),
        .Len_we       (Len_we),
        .Len_in       (Len_in),
        .Overlap_en   (Overlap_en),
        .Clr          (Clr),
        .Match_pulse  (Match_pulse),
        .Match_toggle (Match_toggle),
        .Match_cnt    (Match_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // reference model: symbols accepted since the last flush, newest first
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_pat[ML];
    int            m_len;
    int            m_cnt;
    logic          m_tog;
    logic          m_pulse;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef PAT_MATCH_CNT_EN
        return (n > CMAX) ? CMAX : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        foreach (m_pat[i]) m_pat[i] = '0;
        m_len   = 0;
        m_cnt   = 0;
        m_tog   = 1'b1;
        m_pulse = 1'b0;
    endtask

    task automatic model_edge();
        bit hit;
        m_pulse = 1'b0;
        if (Clr) begin
            m_q.delete();
            m_cnt = 0;
        end else if (Pat_we || Len_we) begin
            if (Pat_we && int'(Pat_addr) < ML)
                m_pat[Pat_addr] = Pat_char;
            if (Len_we)
                m_len = (int'(Len_in) > ML) ? ML : int'(Len_in);
            m_q.delete();
        end else if (Data_valid) begin
            m_q.push_front(Data);
            if (m_q.size() > ML)
                void'(m_q.pop_back());
            hit = (m_len > 0) && (m_q.size() >= m_len);
            for (int i = 0; i < m_len && hit; i++)
                if (m_q[m_len - 1 - i] != m_pat[i])
                    hit = 0;
            if (hit) begin
                m_pulse = 1'b1;
                m_tog   = ~m_tog;
                if (m_cnt < CMAX)
                    m_cnt++;
                if (!Overlap_en)
                    m_q.delete();
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d,
                       input logic pw, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pc, input logic lw,
                       input logic [LW-1:0] li, input logic c);
        Data_valid = v;
        Data       = d;
        Pat_we     = pw;
        Pat_addr   = pa;
        Pat_char   = pc;
        Len_we     = lw;
        Len_in     = li;
        Clr        = c;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check("pulse", 32'(Match_pulse), 32'(m_pulse));
        check("toggle", 32'(Match_toggle), 32'(m_tog));
        check("cnt", 32'(Match_cnt), 32'(exp_cnt(m_cnt)));
        pulses += int'(Match_pulse);
    endtask

    task automatic load_pat(input string s, input logic [LW-1:0] l);
        for (int i = 0; i < s.len(); i++)
            cyc(0, 8'h00, 1, AW'(i), s[i], 0, '0, 0);
        cyc(0, 8'h00, 0, '0, 8'h00, 1, l, 0);
    endtask

    task automatic feed(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            cyc(1, s[i], 0, '0, 8'h00, 0, '0, 0);
            for (int g = 0; g < gap; g++)
                cyc(0, 8'hFF, 0, '0, 8'h00, 0, '0, 0);
        end
    endtask

    task automatic clear();
        cyc(0, 8'h00, 0, '0, 8'h00, 0, '0, 1);
        pulses = 0;
    endtask

    initial begin
        Rst_n      = 1'b0;
        Data_valid = 1'b0;
        Data       = '0;
        Pat_we     = 1'b0;
        Pat_addr   = '0;
        Pat_char   = '0;
        Len_we     = 1'b0;
        Len_in     = '0;
        Overlap_en = 1'b0;
        Clr        = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        check("rst_pulse", 32'(Match_pulse), 32'd0);
        check("rst_toggle", 32'(Match_toggle), 32'd1);
        check("rst_cnt", 32'(Match_cnt), 32'd0);
        Rst_n = 1'b1;

        load_pat("Hello", 5);
        clear();
        feed("xHelloy", 0);
        check("hello_pulses", pulses, 1);
        check("hello_toggle", 32'(Match_toggle), 32'd0);
        check("hello_cnt", 32'(Match_cnt), 32'(exp_cnt(1)));

        load_pat("aba", 3);
        Overlap_en = 1'b1;
        clear();
        feed("ababa", 0);
        check("aba_ov_pulses", pulses, 2);
        check("aba_ov_cnt", 32'(Match_cnt), 32'(exp_cnt(2)));
        Overlap_en = 1'b0;
        clear();
        feed("ababa", 0);
        check("aba_nov_pulses", pulses, 1);
        check("aba_nov_cnt", 32'(Match_cnt), 32'(exp_cnt(1)));

        load_pat("Hello", 5);
        clear();
        feed("Hello", 3);
        check("gap_pulses", pulses, 1);

        load_pat("aaaa", 0);
        clear();
        feed("aaaaaaaaaa", 0);
        check("len0_pulses", pulses, 0);

        load_pat("abcdefgh", 9);
        clear();
        feed("zabcdefgh", 0);
        check("len9_pulses", pulses, 1);

        load_pat("a", 1);
        clear();
        feed("aaaaa", 0);
        check("sat_pulses", pulses, 5);
        check("sat_cnt", 32'(Match_cnt), 32'(exp_cnt(5)));

        load_pat("Hello", 5);
        clear();
        feed("Hell", 0);
        cyc(1, "o", 1, '0, "H", 0, '0, 0);
        check("cfgdrop_pulses", pulses, 0);
        feed("Hello", 0);
        check("cfgdrop_fresh", pulses, 1);

        clear();
        feed("Hel", 0);
        Rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pulse", 32'(Match_pulse), 32'd0);
        check("arst_toggle", 32'(Match_toggle), 32'd1);
        check("arst_cnt", 32'(Match_cnt), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        pulses = 0;
        feed("lo", 0);
        check("arst_pulses", pulses, 0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [DW-1:0] d;
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 9) == 0) ? "c" :
                ($urandom_range(0, 1) != 0 ? "a" : "b");
            if ($urandom_range(0, 49) == 0)
                Overlap_en = ~Overlap_en;
            if (r < 2)
                cyc(1'($urandom), d, 0, '0, 8'h00, 0, '0, 1);
            else if (r < 6)
                cyc(1'($urandom), d, 1, AW'($urandom_range(0, ML - 1)),
                    ($urandom_range(0, 1) != 0) ? "a" : "b", 0, '0, 0);
            else if (r < 8)
                cyc(1'($urandom), d, 0, '0, 8'h00, 1,
                    ($urandom_range(0, 4) == 0) ?
                        LW'($urandom_range(0, 9)) :
                        LW'($urandom_range(1, 4)), 0);
            else
                cyc(($urandom_range(0, 9) < 7), d, 0, '0, 8'h00, 0, '0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
